// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic matrix multiplier: FSM encoding,
// a ceil-log2 helper and default counter widths.
package sys_arr_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  function automatic int sa_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_KMAX = 256;
  localparam int DEF_KW   = sa_clog2(DEF_KMAX + 1);

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: accumulates a*b when both incoming tags are
// valid, with sticky signed overflow, and forwards a right and b down.
module systolic_pe #(
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_b,
  input  logic             i_va,
  input  logic             i_vb,
  output logic [DW-1:0]    o_a,
  output logic [DW-1:0]    o_b,
  output logic             o_va,
  output logic             o_vb,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_x;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_fire;
  logic                    w_of;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_ovf;
  logic [DW-1:0]           r_a;
  logic [DW-1:0]           r_b;
  logic                    r_va;
  logic                    r_vb;

  assign w_fire   = i_va & i_vb;
  assign w_prod   = $signed(i_a) * $signed(i_b);
  assign w_prod_x = ACC_W'(w_prod);
  assign w_sum    = $signed(r_acc) + w_prod_x;
  // Signed overflow: like-signed operands produce a differently-signed sum.
  assign w_of     = (r_acc[ACC_W-1] == w_prod_x[ACC_W-1]) &&
                    (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_va  <= 1'b0;
      r_vb  <= 1'b0;
    end else begin
      r_a  <= i_a;
      r_b  <= i_b;
      r_va <= i_va;
      r_vb <= i_vb;
      if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_fire) begin
        r_acc <= w_sum;
        if (w_of) r_ovf <= 1'b1;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_va  = r_va;
  assign o_vb  = r_vb;
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/systolic_nxn.sv
// N x N output-stationary systolic multiplier C = A*B with streamed k-slices,
// internal input skew, beat/drain sequencing and per-element sticky overflow.
module systolic_nxn
  import sys_arr_pkg::*;
#(
  parameter int N     = 2,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int KMAX  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [sa_clog2(KMAX+1)-1:0]  k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DW-1:0]              a_col,
  input  logic [N*DW-1:0]              b_row,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*ACC_W-1:0]         result,
  output logic [N*N-1:0]               ovf
);

  localparam int KW = sa_clog2(KMAX + 1);
  localparam int CW = sa_clog2(2*N + 1);

  state_t                    r_state;
  logic [KW-1:0]             r_klen;
  logic [KW-1:0]             r_beats;
  logic [CW-1:0]             r_dcnt;
  logic                      w_acc;
  logic                      w_launch;
  logic [N-1:0][DW-1:0]      w_ra;
  logic [N-1:0][DW-1:0]      w_cb;
  logic [N-1:0]              w_sv;
  logic [N-1:0][N-1:0][DW-1:0] w_a;
  logic [N-1:0][N-1:0][DW-1:0] w_b;
  logic [N-1:0][N-1:0]       w_va;
  logic [N-1:0][N-1:0]       w_vb;

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign w_acc    = in_valid & in_ready;
  assign w_launch = start & ((r_state == S_IDLE) || (r_state == S_DONE));

  // Drain counter starts at 1 from LOAD but 0 for k_len=0, giving 2N vs 2N+1
  // cycles to DONE from the respective entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_beats <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_klen  <= k_len;
            r_beats <= '0;
            r_dcnt  <= '0;
            r_state <= (k_len == '0) ? S_DRAIN : S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_beats <= r_beats + 1'b1;
            if (r_beats + 1'b1 == r_klen) begin
              r_dcnt  <= CW'(1);
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == CW'(2*N)) r_state <= S_DONE;
          else                    r_dcnt  <= r_dcnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane l of A and B is delayed by l registers; one shared tag chain per lane.
  for (genvar l = 0; l < N; l++) begin : g_skew
    if (l == 0) begin : g_direct
      assign w_ra[0] = a_col[DW-1:0];
      assign w_cb[0] = b_row[DW-1:0];
      assign w_sv[0] = w_acc;
    end else begin : g_chain
      logic [l-1:0][DW-1:0] r_a;
      logic [l-1:0][DW-1:0] r_b;
      logic [l-1:0]         r_v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_v <= '0;
        end else begin
          r_a[0] <= a_col[l*DW +: DW];
          r_b[0] <= b_row[l*DW +: DW];
          r_v[0] <= w_acc;
          for (int s = 1; s < l; s++) begin
            r_a[s] <= r_a[s-1];
            r_b[s] <= r_b[s-1];
            r_v[s] <= r_v[s-1];
          end
        end
      end
      assign w_ra[l] = r_a[l-1];
      assign w_cb[l] = r_b[l-1];
      assign w_sv[l] = r_v[l-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] w_ai;
      logic [DW-1:0] w_bi;
      logic          w_vai;
      logic          w_vbi;
      if (j == 0) begin : g_left
        assign w_ai  = w_ra[i];
        assign w_vai = w_sv[i];
      end else begin : g_inner_a
        assign w_ai  = w_a[i][j-1];
        assign w_vai = w_va[i][j-1];
      end
      if (i == 0) begin : g_top
        assign w_bi  = w_cb[j];
        assign w_vbi = w_sv[j];
      end else begin : g_inner_b
        assign w_bi  = w_b[i-1][j];
        assign w_vbi = w_vb[i-1][j];
      end
      systolic_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_launch),
        .i_a   (w_ai),
        .i_b   (w_bi),
        .i_va  (w_vai),
        .i_vb  (w_vbi),
        .o_a   (w_a[i][j]),
        .o_b   (w_b[i][j]),
        .o_va  (w_va[i][j]),
        .o_vb  (w_vb[i][j]),
        .o_acc (result[(i*N+j)*ACC_W +: ACC_W]),
        .o_ovf (ovf[i*N+j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_nxn.sv
// Randomized bench for systolic_nxn: N=2 and N=4 instances share the stimulus
// bus; each job is checked against a plain-arithmetic matrix product model.
module tb_systolic_nxn;

  localparam int DW    = 8;
  localparam int ACC_W = 20;
  localparam int KMAX  = 256;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
  localparam longint MODV = 64'sd1 <<< ACC_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         st2, st4;
  logic [8:0]   k_len;
  logic         in_valid;
  logic [31:0]  a_bus, b_bus;
  logic         rdy2, busy2, done2;
  logic [79:0]  res2;
  logic [3:0]   ovf2;
  logic         rdy4, busy4, done4;
  logic [319:0] res4;
  logic [15:0]  ovf4;

  int n_chk = 0;
  int n_pass = 0;
  int gA[4][KMAX];
  int gB[KMAX][4];

  always #5 clk = ~clk;

  systolic_nxn #(.N(2), .DW(DW), .ACC_W(ACC_W), .KMAX(KMAX)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .k_len(k_len), .in_valid(in_valid),
    .in_ready(rdy2), .a_col(a_bus[15:0]), .b_row(b_bus[15:0]), .busy(busy2),
    .done(done2), .result(res2), .ovf(ovf2));

  systolic_nxn #(.N(4), .DW(DW), .ACC_W(ACC_W), .KMAX(KMAX)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .k_len(k_len), .in_valid(in_valid),
    .in_ready(rdy4), .a_col(a_bus), .b_row(b_bus), .busy(busy4),
    .done(done4), .result(res4), .ovf(ovf4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_rdy(input int n);  return (n == 2) ? rdy2 : rdy4;   endfunction
  function automatic logic f_busy(input int n); return (n == 2) ? busy2 : busy4; endfunction
  function automatic logic f_done(input int n); return (n == 2) ? done2 : done4; endfunction
  function automatic logic [ACC_W-1:0] f_res(input int n, input int i, input int j);
    return (n == 2) ? res2[(i*2+j)*ACC_W +: ACC_W] : res4[(i*4+j)*ACC_W +: ACC_W];
  endfunction
  function automatic logic f_ovf(input int n, input int i, input int j);
    return (n == 2) ? ovf2[i*2+j] : ovf4[i*4+j];
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int x = 0; x < 4; x++) begin
        gA[x][kk] = rnd8();
        gB[kk][x] = rnd8();
      end
  endtask

  task automatic drive(input int n, input int b, input logic v);
    a_bus = $urandom;
    b_bus = $urandom;
    if (v)
      for (int x = 0; x < n; x++) begin
        a_bus[x*8 +: 8] = 8'(gA[x][b]);
        b_bus[x*8 +: 8] = 8'(gB[b][x]);
      end
  endtask

  // mode 0: valid held high, 1: toggling 1,0,1,..., 2: random gaps.
  // Returns positioned in the DONE cycle when b2b is set, else one cycle later.
  task automatic run_job(input int n, input int k, input int mode, input bit b2b, input string tag);
    int cyc, beat, last, got_cyc;
    bit got, saw_rdy, fire;
    longint acc;
    bit ov;
    k_len = 9'(k);
    if (n == 2) st2 = 1'b1; else st4 = 1'b1;
    tick;
    st2 = 1'b0;
    st4 = 1'b0;
    chk({tag, " busy"}, 64'(f_busy(n)), 64'd1);
    cyc = 0; beat = 0; last = 0; got = 0; got_cyc = 0; saw_rdy = 0;
    while (!got && cyc < 2000) begin
      if (f_rdy(n)) saw_rdy = 1;
      case (mode)
        0:       in_valid = (beat < k);
        1:       in_valid = (beat < k) && (cyc % 2 == 0);
        default: in_valid = (beat < k) && ($urandom_range(2) != 0);
      endcase
      drive(n, beat, in_valid);
      fire = in_valid && f_rdy(n);
      tick;
      cyc++;
      if (fire) begin
        beat++;
        last = cyc;
      end
      if (f_done(n)) begin
        got = 1;
        got_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    chk({tag, " done seen"}, 64'(got), 64'd1);
    chk({tag, " done latency"}, 64'(got_cyc), 64'((k == 0) ? 2*n + 1 : last + 2*n));
    if (k == 0) chk({tag, " in_ready idle"}, 64'(saw_rdy), 64'd0);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        ov = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc += longint'(gA[i][kk]) * longint'(gB[kk][j]);
          if (acc > MAXV) begin acc -= MODV; ov = 1; end
          else if (acc < MINV) begin acc += MODV; ov = 1; end
        end
        chk($sformatf("%s C%0d%0d", tag, i, j), 64'(f_res(n, i, j)), 64'(acc[ACC_W-1:0]));
        chk($sformatf("%s ovf%0d%0d", tag, i, j), 64'(f_ovf(n, i, j)), 64'(ov));
      end
    if (!b2b) begin
      tick;
      chk({tag, " done pulse"}, 64'(f_done(n)), 64'd0);
      chk({tag, " idle busy"}, 64'(f_busy(n)), 64'd0);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; st2 = 1'b0; st4 = 1'b0; k_len = '0;
    in_valid = 1'b0; a_bus = '0; b_bus = '0;
    repeat (3) tick;
    chk("rst in_ready", 64'(rdy2), 64'd0);
    chk("rst busy", 64'(busy2), 64'd0);
    chk("rst done", 64'(done2), 64'd0);
    chk("rst result", 64'(|res2), 64'd0);
    chk("rst ovf", 64'(ovf2), 64'd0);
    chk("rst n4 any", 64'({rdy4, busy4, done4, |res4, |ovf4}), 64'd0);
    rst = 1'b0;
    tick;

    gA[0][0] = 1; gA[0][1] = 2; gA[1][0] = 3; gA[1][1] = 4;
    gB[0][0] = 5; gB[0][1] = 6; gB[1][0] = 7; gB[1][1] = 8;
    run_job(2, 2, 0, 0, "basic");

    gA[0][0] = -128; gA[0][1] = 127; gA[1][0] = -1; gA[1][1] = 0;
    gB[0][0] = -128; gB[0][1] = 1;   gB[1][0] = 127; gB[1][1] = -1;
    run_job(2, 2, 1, 0, "signed");

    for (int kk = 0; kk < 64; kk++)
      for (int x = 0; x < 2; x++) begin
        gA[x][kk] = -128;
        gB[kk][x] = -128;
      end
    run_job(2, 64, 0, 1, "ovf");
    chk("ovf all set", 64'(ovf2), 64'hf);
    run_job(2, 0, 0, 0, "k0");

    // Reset in the middle of a load.
    fill_rand(5);
    k_len = 9'd5;
    st2 = 1'b1;
    tick;
    st2 = 1'b0;
    in_valid = 1'b1;
    drive(2, 0, 1'b1);
    tick;
    drive(2, 1, 1'b1);
    tick;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("midrst in_ready", 64'(rdy2), 64'd0);
    chk("midrst busy", 64'(busy2), 64'd0);
    chk("midrst done", 64'(done2), 64'd0);
    chk("midrst result", 64'(|res2), 64'd0);
    chk("midrst ovf", 64'(ovf2), 64'd0);
    seen = 0;
    repeat (4) begin
      tick;
      if (done2) seen = 1;
    end
    rst = 1'b0;
    repeat (8) begin
      tick;
      if (done2) seen = 1;
    end
    chk("midrst no done", 64'(seen), 64'd0);

    gA[0][0] = 1; gA[0][1] = 0; gA[1][0] = 0; gA[1][1] = 1;
    gB[0][0] = 9; gB[0][1] = 8; gB[1][0] = 7; gB[1][1] = 6;
    run_job(2, 2, 0, 0, "ident");

    fill_rand(7);
    run_job(2, 7, 2, 1, "b2b0");
    fill_rand(5);
    run_job(2, 5, 2, 0, "b2b1");

    for (int kk = 0; kk < 4; kk++)
      for (int x = 0; x < 4; x++) begin
        gA[x][kk] = (x == kk) ? 1 : 0;
        gB[kk][x] = rnd8();
      end
    run_job(4, 4, 0, 0, "n4 ident");

    for (int r = 0; r < 6; r++) begin
      int k;
      k = int'($urandom_range(1, 12));
      fill_rand(k);
      run_job((r % 2 == 1) ? 4 : 2, k, 2, (r % 3 == 0), $sformatf("rnd%0d", r));
    end
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
